// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : riscv_pkg
// Purpose  : Shared definitions for the multi-cycle RV32I subset core:
//            opcode constants, ALU operation and FSM state enumerations,
//            default reset PC and funct3 decode helpers.
// Revision : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_SLT,
        ALU_SLTU
    } alu_op_e;

    typedef enum logic [1:0] {
        FETCH,
        EXEC,
        MEM,
        HALT
    } state_e;

    // funct3 values shared by OP and OP-IMM; shifts (001/101) are not supported
    function automatic logic f3_is_alu(input logic [2:0] f3);
        return (f3 != 3'b001) && (f3 != 3'b101);
    endfunction

    function automatic alu_op_e alu_op_from_f3(input logic [2:0] f3);
        case (f3)
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b110:  return ALU_OR;
            3'b111:  return ALU_AND;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/riscv_alu.sv
`default_nettype none
// ============================================================================
// Module   : riscv_alu
// Purpose  : Combinational 32-bit ALU used for arithmetic/logic results,
//            load/store address generation and branch comparison.
// Revision : 1.0 - initial release
// ============================================================================
module riscv_alu
    import riscv_pkg::*;
(
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  alu_op_e     op_i,
    output logic [31:0] result_o
);

    // Result select; all arithmetic wraps modulo 2^32
    always_comb begin
        result_o = 32'd0;
        case (op_i)
            ALU_ADD:  result_o = a_i + b_i;
            ALU_SUB:  result_o = a_i - b_i;
            ALU_AND:  result_o = a_i & b_i;
            ALU_OR:   result_o = a_i | b_i;
            ALU_XOR:  result_o = a_i ^ b_i;
            ALU_SLT:  result_o = {31'd0, $signed(a_i) < $signed(b_i)};
            ALU_SLTU: result_o = {31'd0, a_i < b_i};
            default:  result_o = 32'd0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/riscv_core_mc.sv
`default_nettype none
// ============================================================================
// Module   : riscv_core_mc
// Purpose  : Multi-cycle RV32I subset core (FETCH/EXEC/MEM/HALT), one
//            request/ack instruction port and one request/ack data port.
//            Optional macro RISCV_CORE_BRANCH_EN adds BEQ/BNE/BLT/BGE/
//            BLTU/BGEU/JAL/JALR; without it those opcodes halt the core.
// Revision : 1.0 - initial release
// ============================================================================
module riscv_core_mc
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          NUM_REGS = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        retire,
    output logic        halted,
    output logic [31:0] pc_debug
);

    localparam int IDXW = $clog2(NUM_REGS);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic        halted_q, halted_d;
    logic [31:0] regs_q [NUM_REGS];

    logic [6:0]  opcode, funct7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [31:0] imm_i, imm_s, imm_u;
    logic [31:0] rs1_val, rs2_val, pc_plus4;

    logic [31:0] alu_a, alu_b, alu_res;
    alu_op_e     alu_op;
    logic        dec_ok, uses_rd, uses_rs1, uses_rs2;
    logic        is_mem, is_store, is_link;
    logic        taken, legal;
    logic [31:0] target;
    logic        rf_we;
    logic [31:0] rf_wdata;

`ifdef RISCV_CORE_BRANCH_EN
    logic [31:0] imm_b, imm_j;
    logic        is_branch, is_jal, is_jalr;
    assign imm_b = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
    assign imm_j = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
`endif

    assign opcode   = ir_q[6:0];
    assign rd       = ir_q[11:7];
    assign funct3   = ir_q[14:12];
    assign rs1      = ir_q[19:15];
    assign rs2      = ir_q[24:20];
    assign funct7   = ir_q[31:25];
    assign imm_i    = {{20{ir_q[31]}}, ir_q[31:20]};
    assign imm_s    = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
    assign imm_u    = {ir_q[31:12], 12'd0};
    assign pc_plus4 = pc_q + 32'd4;

    // x0 and indices beyond the implemented file read as zero
    assign rs1_val = (rs1 != 5'd0 && int'(rs1) < NUM_REGS) ? regs_q[rs1[IDXW-1:0]] : 32'd0;
    assign rs2_val = (rs2 != 5'd0 && int'(rs2) < NUM_REGS) ? regs_q[rs2[IDXW-1:0]] : 32'd0;

    riscv_alu u_alu (
        .a_i      (alu_a),
        .b_i      (alu_b),
        .op_i     (alu_op),
        .result_o (alu_res)
    );

    // Decode: ALU operand/op selection and instruction class flags
    always_comb begin
        alu_a    = rs1_val;
        alu_b    = rs2_val;
        alu_op   = ALU_ADD;
        dec_ok   = 1'b0;
        uses_rd  = 1'b0;
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        is_mem   = 1'b0;
        is_store = 1'b0;
        is_link  = 1'b0;
`ifdef RISCV_CORE_BRANCH_EN
        is_branch = 1'b0;
        is_jal    = 1'b0;
        is_jalr   = 1'b0;
`endif
        case (opcode)
            OPC_OP: begin
                uses_rd  = 1'b1;
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
                if (funct7 == 7'b0000000) begin
                    dec_ok = f3_is_alu(funct3);
                    alu_op = alu_op_from_f3(funct3);
                end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
                    dec_ok = 1'b1;
                    alu_op = ALU_SUB;
                end
            end
            OPC_OP_IMM: begin
                uses_rd  = 1'b1;
                uses_rs1 = 1'b1;
                alu_b    = imm_i;
                dec_ok   = f3_is_alu(funct3);
                alu_op   = alu_op_from_f3(funct3);
            end
            OPC_LUI: begin
                uses_rd = 1'b1;
                alu_a   = 32'd0;
                alu_b   = imm_u;
                dec_ok  = 1'b1;
            end
            OPC_AUIPC: begin
                uses_rd = 1'b1;
                alu_a   = pc_q;
                alu_b   = imm_u;
                dec_ok  = 1'b1;
            end
            OPC_LOAD: begin
                uses_rd  = 1'b1;
                uses_rs1 = 1'b1;
                alu_b    = imm_i;
                is_mem   = 1'b1;
                dec_ok   = (funct3 == 3'b010);
            end
            OPC_STORE: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
                alu_b    = imm_s;
                is_mem   = 1'b1;
                is_store = 1'b1;
                dec_ok   = (funct3 == 3'b010);
            end
`ifdef RISCV_CORE_BRANCH_EN
            OPC_BRANCH: begin
                uses_rs1  = 1'b1;
                uses_rs2  = 1'b1;
                is_branch = 1'b1;
                dec_ok    = (funct3 != 3'b010) && (funct3 != 3'b011);
                alu_op    = funct3[2] ? (funct3[1] ? ALU_SLTU : ALU_SLT) : ALU_SUB;
            end
            OPC_JAL: begin
                uses_rd = 1'b1;
                is_jal  = 1'b1;
                is_link = 1'b1;
                dec_ok  = 1'b1;
            end
            OPC_JALR: begin
                uses_rd  = 1'b1;
                uses_rs1 = 1'b1;
                alu_b    = imm_i;
                is_jalr  = 1'b1;
                is_link  = 1'b1;
                dec_ok   = (funct3 == 3'b000);
            end
`endif
            default: dec_ok = 1'b0;
        endcase
    end

    // Control-flow target and final legality (needs the ALU result)
    always_comb begin
        taken  = 1'b0;
        target = pc_plus4;
`ifdef RISCV_CORE_BRANCH_EN
        if (is_jalr) begin
            taken  = 1'b1;
            target = {alu_res[31:1], 1'b0};
        end else if (is_jal) begin
            taken  = 1'b1;
            target = pc_q + imm_j;
        end else if (is_branch) begin
            target = pc_q + imm_b;
            taken  = (funct3[2] ? alu_res[0] : (alu_res == 32'd0)) ^ funct3[0];
        end
`endif
        legal = dec_ok;
        if (uses_rd  && int'(rd)  >= NUM_REGS) legal = 1'b0;
        if (uses_rs1 && int'(rs1) >= NUM_REGS) legal = 1'b0;
        if (uses_rs2 && int'(rs2) >= NUM_REGS) legal = 1'b0;
        if (is_mem && alu_res[1:0] != 2'b00)   legal = 1'b0;
        if (taken && target[1])                legal = 1'b0;
    end

    // FSM next state, PC/IR update, register write-back and retire pulse
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        halted_d = halted_q;
        rf_we    = 1'b0;
        rf_wdata = alu_res;
        retire   = 1'b0;
        case (state_q)
            FETCH: begin
                if (imem_ack) begin
                    ir_d    = imem_rdata;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (!legal) begin
                    halted_d = 1'b1;
                    state_d  = HALT;
                end else if (is_mem) begin
                    state_d = MEM;
                end else begin
                    rf_we   = uses_rd;
                    if (is_link) rf_wdata = pc_plus4;
                    pc_d    = taken ? target : pc_plus4;
                    retire  = 1'b1;
                    state_d = FETCH;
                end
            end
            MEM: begin
                if (dmem_ack) begin
                    rf_we    = !is_store;
                    rf_wdata = dmem_rdata;
                    pc_d     = pc_plus4;
                    retire   = 1'b1;
                    state_d  = FETCH;
                end
            end
            HALT: halted_d = 1'b1;
            default: state_d = FETCH;
        endcase
    end

    // Architectural state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= FETCH;
            pc_q     <= RESET_PC;
            ir_q     <= 32'd0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            halted_q <= halted_d;
        end
    end

    // Register file; x0 is never written
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= 32'd0;
        end else if (rf_we && rd != 5'd0) begin
            regs_q[rd[IDXW-1:0]] <= rf_wdata;
        end
    end

    // Fetch request is masked during reset so it drops with rst_n
    assign imem_req   = rst_n && (state_q == FETCH);
    assign imem_addr  = pc_q;
    assign pc_debug   = pc_q;
    assign dmem_req   = (state_q == MEM);
    assign dmem_we    = (state_q == MEM) && is_store;
    assign dmem_addr  = (state_q == MEM) ? alu_res : 32'd0;
    assign dmem_wdata = ((state_q == MEM) && is_store) ? rs2_val : 32'd0;
    assign halted     = halted_q;

endmodule
`default_nettype wire

// File: tb/tb_riscv_core_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_riscv_core_mc
// Purpose  : Directed self-checking bench for riscv_core_mc (NUM_REGS=32
//            main instance plus a NUM_REGS=16 instance for RV32E checks).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_riscv_core_mc;

    localparam logic [31:0] C_RST_PC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        imem_req, imem_ack, dmem_req, dmem_we, dmem_ack, retire, halted;
    logic [31:0] imem_addr, imem_rdata, dmem_addr, dmem_wdata, dmem_rdata, pc_debug;

    logic        imem_req16, dmem_req16, dmem_we16, retire16, halted16;
    logic [31:0] imem_addr16, dmem_addr16, dmem_wdata16, pc_debug16;

    logic [31:0] prog [16];
    logic [31:0] dmem [256] = '{default: 32'd0};
    int          dmem_delay = 0;
    int          dcnt = 0;
    logic        late_ack = 1'b0;
    logic [31:0] w_off;

    int n_checks = 0;
    int n_errors = 0;

    riscv_core_mc #(.RESET_PC(C_RST_PC), .NUM_REGS(32)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .retire(retire), .halted(halted), .pc_debug(pc_debug)
    );

    // RV32E instance always fetches ADDI x20,x0,1
    riscv_core_mc #(.RESET_PC(C_RST_PC), .NUM_REGS(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req16), .imem_addr(imem_addr16), .imem_ack(imem_req16), .imem_rdata(32'h00100A13),
        .dmem_req(dmem_req16), .dmem_we(dmem_we16), .dmem_addr(dmem_addr16), .dmem_wdata(dmem_wdata16),
        .dmem_ack(1'b0), .dmem_rdata(32'd0),
        .retire(retire16), .halted(halted16), .pc_debug(pc_debug16)
    );

    // Zero-wait instruction memory
    assign imem_ack = imem_req;
    always_comb begin
        w_off      = imem_addr - C_RST_PC;
        imem_rdata = (w_off < 32'd64) ? prog[w_off[5:2]] : 32'd0;
    end

    // Data memory with programmable wait cycles
    assign dmem_ack   = (dmem_req && dcnt == dmem_delay) || late_ack;
    assign dmem_rdata = dmem[dmem_addr[9:2]];
    always @(posedge clk) begin
        if (dmem_req && !dmem_ack) dcnt <= dcnt + 1;
        else                       dcnt <= 0;
        if (dmem_req && dmem_ack && dmem_we) dmem[dmem_addr[9:2]] <= dmem_wdata;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Activity logs, cleared while reset is held
    int          cyc = 0;
    int          dreq_n = 0;
    int          ret16_n = 0;
    logic [31:0] fetch_q [$];
    int          ret_q [$];
    logic [64:0] dtr_q [$];
    logic        pv_wait = 1'b0, pv_we = 1'b0;
    logic [31:0] pv_addr = 32'd0, pv_wdata = 32'd0;

    always @(negedge clk) begin
        if (!rst_n) begin
            cyc <= 0;
            dreq_n <= 0;
            ret16_n <= 0;
            pv_wait <= 1'b0;
            fetch_q.delete();
            ret_q.delete();
            dtr_q.delete();
        end else begin
            cyc <= cyc + 1;
            if (imem_req && imem_ack) fetch_q.push_back(imem_addr);
            if (retire) ret_q.push_back(cyc);
            if (retire16) ret16_n <= ret16_n + 1;
            if (dmem_req) begin
                dreq_n <= dreq_n + 1;
                if (pv_wait) begin
                    check_eq("dmem_addr_stable", dmem_addr, pv_addr);
                    check_eq("dmem_wdata_stable", dmem_wdata, pv_wdata);
                    check_eq("dmem_we_stable", {31'd0, dmem_we}, {31'd0, pv_we});
                end
                if (dmem_ack) dtr_q.push_back({dmem_we, dmem_addr, dmem_wdata});
            end
            pv_wait  <= dmem_req && !dmem_ack;
            pv_addr  <= dmem_addr;
            pv_wdata <= dmem_wdata;
            pv_we    <= dmem_we;
        end
    end

    task automatic assert_rst();
        @(posedge clk); #2 rst_n = 1'b0;
    endtask

    task automatic release_rst();
        @(posedge clk); #2 rst_n = 1'b1;
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 16; i++) prog[i] = 32'd0;
    endtask

    task automatic wait_halt(input int budget, input string tag);
        int n;
        n = 0;
        while (!halted && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_halted"}, {31'd0, halted}, 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_imem_req"},   {31'd0, imem_req}, 32'd0);
        check_eq({tag, "_dmem_req"},   {31'd0, dmem_req}, 32'd0);
        check_eq({tag, "_dmem_we"},    {31'd0, dmem_we},  32'd0);
        check_eq({tag, "_retire"},     {31'd0, retire},   32'd0);
        check_eq({tag, "_halted"},     {31'd0, halted},   32'd0);
        check_eq({tag, "_imem_addr"},  imem_addr,  C_RST_PC);
        check_eq({tag, "_pc_debug"},   pc_debug,   C_RST_PC);
        check_eq({tag, "_dmem_addr"},  dmem_addr,  32'd0);
        check_eq({tag, "_dmem_wdata"}, dmem_wdata, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [64:0] t;
        int          nf;

        // ---- A: ALU ops, store/load with 3 wait cycles ----
        clear_prog();
        prog[0] = 32'h00500093;   // ADDI x1,x0,5
        prog[1] = 32'h00108133;   // ADD  x2,x1,x1
        prog[2] = 32'h10202023;   // SW   x2,0x100(x0)
        prog[3] = 32'h10002183;   // LW   x3,0x100(x0)
        prog[4] = 32'h10302223;   // SW   x3,0x104(x0)
        dmem_delay = 3;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("rst0");
        release_rst();
        wait_halt(200, "A");
        check_eq("A_fetch0", fetch_q[0], C_RST_PC);
        check_eq("A_fetch1", fetch_q[1], C_RST_PC + 32'd4);
        check_eq("A_nretire", 32'(ret_q.size()), 32'd5);
        check_eq("A_gap_alu", 32'(ret_q[1] - ret_q[0]), 32'd2);
        check_eq("A_gap_sw",  32'(ret_q[2] - ret_q[1]), 32'd6);
        check_eq("A_gap_lw",  32'(ret_q[3] - ret_q[2]), 32'd6);
        t = dtr_q[0];
        check_eq("A_sw_we",    {31'd0, t[64]}, 32'd1);
        check_eq("A_sw_addr",  t[63:32], 32'h100);
        check_eq("A_sw_wdata", t[31:0], 32'd10);
        t = dtr_q[1];
        check_eq("A_lw_we",    {31'd0, t[64]}, 32'd0);
        check_eq("A_lw_addr",  t[63:32], 32'h100);
        check_eq("A_mem100", dmem[64], 32'd10);
        check_eq("A_mem104_x3", dmem[65], 32'd10);
        nf = fetch_q.size();
        check_eq("A_nfetch", 32'(nf), 32'd6);
        repeat (5) @(negedge clk);
        check_eq("A_nofetch_after_halt", 32'(fetch_q.size()), 32'(nf));
        check_eq("A_halt_imem_req", {31'd0, imem_req}, 32'd0);
        check_eq("A_halt_retire", {31'd0, retire}, 32'd0);
        // async reset out of HALT
        assert_rst();
        #1;
        check_reset_outputs("rst1");

        // ---- B: misaligned LW halts without dmem access ----
        clear_prog();
        prog[0] = 32'h00700293;   // ADDI x5,x0,7
        prog[1] = 32'h10200313;   // ADDI x6,x0,0x102
        prog[2] = 32'h00032283;   // LW   x5,0(x6)
        dmem_delay = 0;
        release_rst();
        wait_halt(100, "B");
        repeat (5) @(negedge clk);
        check_eq("B_no_dmem_req", 32'(dreq_n), 32'd0);
        check_eq("B_nfetch", 32'(fetch_q.size()), 32'd3);
        check_eq("B_nretire", 32'(ret_q.size()), 32'd2);
        check_eq("B_x5_kept", u_dut.regs_q[5], 32'd7);
        assert_rst();

        // ---- C: x20 with 32 regs works, with 16 regs halts ----
        clear_prog();
        prog[0] = 32'h00100A13;   // ADDI x20,x0,1
        prog[1] = 32'h21402023;   // SW   x20,0x200(x0)
        release_rst();
        wait_halt(100, "C");
        check_eq("C_mem200_x20", dmem[128], 32'd1);
        check_eq("C16_halted", {31'd0, halted16}, 32'd1);
        check_eq("C16_no_retire", 32'(ret16_n), 32'd0);
        check_eq("C16_imem_req", {31'd0, imem_req16}, 32'd0);
        check_eq("C16_dmem", {29'd0, dmem_req16, dmem_we16, |dmem_addr16}, 32'd0);
        check_eq("C16_wdata", dmem_wdata16, 32'd0);
        check_eq("C16_pc", pc_debug16, C_RST_PC);
        check_eq("C16_iaddr", imem_addr16, C_RST_PC);
        assert_rst();

        // ---- D: reset during MEM, late ack ignored ----
        clear_prog();
        prog[0] = 32'h00900093;   // ADDI x1,x0,9
        prog[1] = 32'h00102823;   // SW   x1,0x10(x0)
        dmem_delay = 10;
        release_rst();
        nf = 0;
        while (!dmem_req && nf < 20) begin
            @(negedge clk);
            nf++;
        end
        check_eq("D_reached_mem", {31'd0, dmem_req}, 32'd1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check_eq("D_rst_dmem_req", {31'd0, dmem_req}, 32'd0);
        check_eq("D_rst_imem_req", {31'd0, imem_req}, 32'd0);
        check_eq("D_rst_dmem_addr", dmem_addr, 32'd0);
        check_eq("D_rst_imem_addr", imem_addr, C_RST_PC);
        @(posedge clk);
        #2 rst_n = 1'b1;
        late_ack = 1'b1;
        repeat (2) @(posedge clk);
        #2 late_ack = 1'b0;
        wait_halt(100, "D");
        check_eq("D_first_fetch", fetch_q[0], C_RST_PC);
        check_eq("D_nfetch", 32'(fetch_q.size()), 32'd3);
        check_eq("D_nretire", 32'(ret_q.size()), 32'd2);
        check_eq("D_gap_sw10", 32'(ret_q[1] - ret_q[0]), 32'd13);
        check_eq("D_ntrans", 32'(dtr_q.size()), 32'd1);
        check_eq("D_mem10", dmem[4], 32'd9);
        assert_rst();

        // ---- E: branch / jump ----
        clear_prog();
        prog[0] = 32'h00500093;   // ADDI x1,x0,5
        prog[1] = 32'h00009463;   // BNE  x1,x0,+8
        prog[3] = 32'h010000EF;   // JAL  x1,+16
        prog[7] = 32'h02102023;   // SW   x1,0x20(x0)
        dmem_delay = 0;
        release_rst();
        wait_halt(100, "E");
`ifdef RISCV_CORE_BRANCH_EN
        check_eq("E_nfetch", 32'(fetch_q.size()), 32'd5);
        check_eq("E_bne_target", fetch_q[2], C_RST_PC + 32'h0C);
        check_eq("E_jal_target", fetch_q[3], C_RST_PC + 32'h1C);
        check_eq("E_jal_link", dmem[8], C_RST_PC + 32'h10);
        check_eq("E_nretire", 32'(ret_q.size()), 32'd4);
`else
        check_eq("E_nfetch", 32'(fetch_q.size()), 32'd2);
        check_eq("E_fetch1", fetch_q[1], C_RST_PC + 32'd4);
        check_eq("E_nretire", 32'(ret_q.size()), 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/riscv_core_mc.md
RISCV_CORE_MC -- requirements
Module: riscv_core_mc

Interface
REQ-001 SHALL have parameter RESET_PC, 32'h8000_0000, PC value loaded on reset.
REQ-002 SHALL have parameter NUM_REGS, 32, register count; legal values 16 (RV32E) or 32.
REQ-003 SHALL have port clk  in  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port imem_req  out  1  instruction fetch request, held until imem_ack.
REQ-006 SHALL have port imem_addr  out  32  fetch address, equal to PC.
REQ-007 SHALL have port imem_ack  in  1  fetch complete; imem_rdata valid in the same cycle.
REQ-008 SHALL have port imem_rdata  in  32  instruction word.
REQ-009 SHALL have port dmem_req  out  1  data request, held until dmem_ack.
REQ-010 SHALL have port dmem_we  out  1  1 = store, 0 = load; valid while dmem_req.
REQ-011 SHALL have port dmem_addr  out  32  word-aligned data address.
REQ-012 SHALL have port dmem_wdata  out  32  store data (rs2).
REQ-013 SHALL have port dmem_ack  in  1  data complete; dmem_rdata valid in the same cycle for loads.
REQ-014 SHALL have port dmem_rdata  in  32  load data.
REQ-015 SHALL have port retire  out  1  one-cycle pulse per completed instruction.
REQ-016 SHALL have port halted  out  1  sticky; set on illegal instruction.
REQ-017 SHALL have port pc_debug  out  32  current PC.

Function
REQ-018 SHALL use FSM states FETCH, EXEC, MEM, HALT.
- FETCH: imem_req=1; on imem_ack, latch imem_rdata into IR and go to EXEC.
- EXEC: decode and execute from IR; loads and stores go to MEM; all other instructions write back, update PC, pulse retire, and return to FETCH.
- MEM: dmem_req=1; on dmem_ack, loads write rd; PC+=4, retire, FETCH.
REQ-019 SHALL execute OP ADD/SUB/AND/OR/XOR/SLT/SLTU, OP-IMM ADDI/ANDI/ORI/XORI/SLTI/SLTIU, LUI, AUIPC, LW, SW; all arithmetic modulo 2^32.
REQ-020 SHALL sign-extend I/S immediates; SLT/SLTI compare signed; SLTU/SLTIU compare unsigned.
REQ-021 SHALL treat as illegal, and enter HALT without writing rd or PC:
- any other opcode;
- funct3/funct7 combinations not listed;
- LW/SW address[1:0] != 0;
- any register index >= NUM_REGS.
REQ-022 SHALL latch halted=1 in HALT, deassert both req outputs, keep retire=0, and stay in HALT until reset.
REQ-023 SHALL ignore writes to x0; x0 SHALL read as 0.
REQ-024 SHALL hold imem_addr, dmem_addr, dmem_we and dmem_wdata stable while the corresponding req is high; an ack seen while req is low SHALL be ignored.
REQ-025 SHALL take 2 cycles per non-memory instruction and 3 cycles per LW/SW with zero-wait acks (ack in the first req cycle); each wait cycle adds 1.
REQ-026 SHALL make the rd value visible to the next instruction's EXEC cycle (no stale reads).

Reset
REQ-027 SHALL, on rst_n low, asynchronously:
- force state to FETCH and PC to RESET_PC;
- clear all registers, IR, and the halted flag;
- drive imem_req, dmem_req, dmem_we and retire to 0;
- return all data/address outputs to 0, except imem_addr and pc_debug, which equal RESET_PC.
REQ-028 SHALL, on reset during an outstanding request, drop the request immediately, discard the pending transaction, and issue the first fetch in the first clock after rst_n rises.

Configuration
REQ-029 SHALL, with RISCV_CORE_BRANCH_EN defined, support BEQ/BNE/BLT/BGE/BLTU/BGEU/JAL/JALR.
- Targets are computed in EXEC; JAL/JALR write PC+4 to rd.
- JALR clears target bit 0.
- A target with bit 1 set is illegal (HALT).
REQ-030 SHALL, without RISCV_CORE_BRANCH_EN, treat the branch, JAL and JALR opcodes as illegal (REQ-021).

Structure
REQ-031 SHALL place the following in package riscv_pkg: opcode constants, the ALU-op enumeration, the FSM state enumeration, and the RESET_PC default.
REQ-032 SHALL implement the ALU as combinational sub-module riscv_alu (32-bit a, b, op -> result) shared by ALU instructions, address calculation and branch comparison.

Verification
REQ-033 SHALL cover: reset, then zero-wait ADDI x1,x0,5; ADD x2,x1,x1 -> x2=10; retire pulses 2 cycles apart; imem_addr 0x80000000, then 0x80000004.
REQ-034 SHALL cover: SW x2,0x100(x0) with 3-cycle dmem_ack delay, then LW x3,0x100(x0) -> dmem_req held with stable addr=0x100, wdata=10; x3=10.
REQ-035 SHALL cover: LW with address 0x102 -> halted=1, no dmem_req, rd unchanged; later fetches absent.
REQ-036 SHALL cover: NUM_REGS=16 with ADDI x20,x0,1 -> halted=1; the same instruction with NUM_REGS=32 -> x20=1.
REQ-037 SHALL cover: rst_n pulsed low mid-MEM with dmem_req=1 -> dmem_req=0 immediately; after release, first imem_addr=RESET_PC; late dmem_ack ignored.
REQ-038 SHALL cover, with RISCV_CORE_BRANCH_EN: BNE x1,x0,+8 with x1=5 -> next imem_addr = PC+8; JAL x1,+16 -> x1=PC+4. Without RISCV_CORE_BRANCH_EN, the same BNE -> halted=1.
